// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      REFILL = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam int          PC_STEP           = 4;

endpackage

// File: rtl/fetch_control_unit_if.sv
// Control, instruction-memory and IF/ID signals of the fetch unit.
interface fetch_control_unit_if #(
   parameter int N = 32
);

   logic          select_pc;
   logic          flush;
   logic          stall;
   logic [N-1:0]  branch_target;
   logic [31:0]   imem_rdata;
   logic [N-1:0]  imem_addr;
   logic          imem_en;
   logic [31:0]   instr_D;
   logic [N-1:0]  pc_D;
   logic          valid_D;
   logic          kill_E;
   logic [15:0]   flush_count;

   modport master (
      output select_pc, flush, stall, branch_target, imem_rdata,
      input  imem_addr, imem_en, instr_D, pc_D, valid_D, kill_E, flush_count
   );

   modport slave (
      input  select_pc, flush, stall, branch_target, imem_rdata,
      output imem_addr, imem_en, instr_D, pc_D, valid_D, kill_E, flush_count
   );

endinterface

// File: rtl/fetch_control_unit_sat_counter.sv
// Counter that increments on inc and sticks at its all-ones value.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch stage: PC sequencing, redirect refill and the IF/ID pipeline register.
module fetch_control_unit
   import fetch_pkg::*;
#(
   parameter int          N         = 32,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic                  clk,
   input logic                  rst,
   fetch_control_unit_if.slave  bus
);

   fetch_state_e state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] pc_f_q, pc_f_d;
   logic         fvalid_q, fvalid_d;
   logic [31:0]  dec_instr_q, dec_instr_d;
   logic [N-1:0] dec_pc_q, dec_pc_d;
   logic         dec_valid_q, dec_valid_d;
   logic         imem_en;
   logic [N-1:0] target_aligned;

   assign target_aligned = bus.branch_target & ~N'(3);

   // The read issued in the redirect cycle returns stale data, so REFILL only
   // launches the first read at the target; decode is fed from RUN onwards.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pc_f_d      = pc_f_q;
      fvalid_d    = fvalid_q;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      dec_valid_d = dec_valid_q;
      imem_en     = 1'b0;
      if (!rst) begin
         if (bus.select_pc) begin
            pc_d        = target_aligned;
            fvalid_d    = 1'b0;
            dec_instr_d = NOP_INSTR;
            dec_valid_d = 1'b0;
            state_d     = REFILL;
            imem_en     = 1'b1;
         end else begin
            if (!bus.stall) begin
               imem_en  = 1'b1;
               pc_f_d   = pc_q;
               fvalid_d = 1'b1;
               pc_d     = pc_q + N'(PC_STEP);
               state_d  = RUN;
               if (state_q == RUN) begin
                  dec_instr_d = bus.imem_rdata;
                  dec_pc_d    = pc_f_q;
                  dec_valid_d = fvalid_q;
               end
            end
            if (bus.flush) begin
               dec_instr_d = NOP_INSTR;
               dec_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= REFILL;
         pc_q        <= RESET_PC;
         pc_f_q      <= '0;
         fvalid_q    <= 1'b0;
         dec_instr_q <= NOP_INSTR;
         dec_pc_q    <= '0;
         dec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_f_q      <= pc_f_d;
         fvalid_q    <= fvalid_d;
         dec_instr_q <= dec_instr_d;
         dec_pc_q    <= dec_pc_d;
         dec_valid_q <= dec_valid_d;
      end
   end

   sat_counter #(
      .W (16)
   ) u_flush_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.select_pc & ~rst),
      .count (bus.flush_count)
   );

   assign bus.imem_addr = pc_q;
   assign bus.imem_en   = imem_en;
   assign bus.instr_D   = dec_instr_q;
   assign bus.pc_D      = dec_pc_q;
   assign bus.valid_D   = dec_valid_q;
   assign bus.kill_E    = bus.flush;

endmodule
